// File: rtl/dec_4x16_bist_pkg.sv
// Shared types and helpers for the 4x16 decoder self-test block.
// State encoding, widths and the golden one-hot function.
package dec_4x16_bist_pkg;

    localparam int SEL_W = 4;
    localparam int OUT_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [OUT_W-1:0] golden_onehot(
        input logic [SEL_W-1:0] code
    );
        logic [OUT_W-1:0] g;
        g = '0;
        g[code] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/dec_4x16_bist_if.sv
// Control, result and decoder-facing signals of the decoder self-test.
// The slave side is the test engine; the master side drives it.
interface dec_4x16_bist_if;
    import dec_4x16_bist_pkg::*;

    logic             start;
    logic [OUT_W-1:0] dec_in;
    logic [SEL_W-1:0] sel_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SEL_W:0]   fail_count;
    logic [SEL_W-1:0] first_fail_code;
    logic [OUT_W-1:0] first_fail_syn;
    logic [OUT_W-1:0] fault_map;

    modport slave (
        input  start,
        input  dec_in,
        output sel_out,
        output busy,
        output done,
        output pass,
        output fail_count,
        output first_fail_code,
        output first_fail_syn,
        output fault_map
    );

    modport master (
        output start,
        output dec_in,
        input  sel_out,
        input  busy,
        input  done,
        input  pass,
        input  fail_count,
        input  first_fail_code,
        input  first_fail_syn,
        input  fault_map
    );

endinterface

// File: rtl/dec_4x16_bist_cmp.sv
// Compares one decoder sample against the golden one-hot value.
// Unknown bits on the sample count as a mismatch.
module dec_4x16_bist_cmp
    import dec_4x16_bist_pkg::*;
(
    input  logic [SEL_W-1:0] code,
    input  logic [OUT_W-1:0] dec_in,
    output logic [OUT_W-1:0] golden,
    output logic [OUT_W-1:0] syn,
    output logic             mismatch
);

    always_comb begin
        golden   = golden_onehot(code);
        syn      = dec_in ^ golden;
        // Case equality so X/Z on the sample still flags the code.
        mismatch = (dec_in === golden) ? 1'b0 : 1'b1;
    end

endmodule

// File: rtl/dec_4x16_bist.sv
// Self-test sequencer: walks all select codes, checks each decoder
// sample and accumulates count, first failure and per-output fault map.
module dec_4x16_bist
    import dec_4x16_bist_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dec_4x16_bist_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] CODE_LAST   = {SEL_W{1'b1}};

    state_t           state;
    state_t           state_n;
    logic             launch;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] code;
    logic [SEL_W:0]   fail_count;
    logic [SEL_W-1:0] first_code;
    logic [OUT_W-1:0] first_syn;
    logic [OUT_W-1:0] fault_map;
    logic [OUT_W-1:0] cmp_golden_unused;
    logic [OUT_W-1:0] syn;
    logic             mismatch;

    dec_4x16_bist_cmp u_cmp (
        .code     (code),
        .dec_in   (bus.dec_in),
        .golden   (cmp_golden_unused),
        .syn      (syn),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    launch  = 1'b1;
                    state_n = APPLY;
                end
            end
            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                state_n = (code == CODE_LAST) ? DONE : APPLY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            code       <= '0;
            fail_count <= '0;
            first_code <= '0;
            first_syn  <= '0;
            fault_map  <= '0;
        end else if (launch) begin
            cnt        <= '0;
            code       <= '0;
            fail_count <= '0;
            first_code <= '0;
            first_syn  <= '0;
            fault_map  <= '0;
        end else if (state == APPLY) begin
            cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
        end else if (state == SAMPLE) begin
            if (mismatch) begin
                fail_count <= fail_count + 1'b1;
                if (fail_count == '0) begin
                    first_code <= code;
                    first_syn  <= syn;
                end
            end
            fault_map <= fault_map | syn;
            // Code 15 stays put so sel_out never wraps mid-run.
            if (code != CODE_LAST) begin
                code <= code + 1'b1;
            end
        end
    end

    assign bus.sel_out         = code;
    assign bus.busy            = (state == APPLY) || (state == SAMPLE);
    assign bus.done            = (state == DONE);
    assign bus.pass            = (state == DONE) && (fail_count == '0);
    assign bus.fail_count      = fail_count;
    assign bus.first_fail_code = first_code;
    assign bus.first_fail_syn  = first_syn;
    assign bus.fault_map       = fault_map;

endmodule

// File: tb/tb_dec_4x16_bist.sv
// Directed bench for the decoder self-test: behavioural decoder with
// selectable faults, hand-computed results per run.
module tb_dec_4x16_bist;

    logic clk;
    logic rst_n;
    int   mode;
    int   vectors;
    int   miscompares;

    dec_4x16_bist_if bus ();

    dec_4x16_bist #(.SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder under test: 0 good, 1 D5 sa0, 2 upper half off,
    // 3 W inverted in lower half, 4 all outputs stuck at 0.
    logic [15:0] dm;
    always_comb begin
        dm = 16'h0001 << bus.sel_out;
        case (mode)
            1: dm[5] = 1'b0;
            2: dm[15:8] = 8'h00;
            3: if (!bus.sel_out[3])
                   dm = 16'h0001 << {bus.sel_out[3:1], ~bus.sel_out[0]};
            4: dm = 16'h0000;
            default: ;
        endcase
        bus.dec_in = dm;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {12'h000, bus.sel_out, bus.busy, bus.done, bus.pass,
                bus.fail_count, bus.first_fail_code,
                bus.first_fail_syn, bus.fault_map};
    endfunction

    task automatic run(input string name, input int m, input int poke,
                       input logic ps, input logic [4:0] fc,
                       input logic [3:0] ffc, input logic [15:0] fsyn,
                       input logic [15:0] fmap);
        @(negedge clk);
        mode = m;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, ".launch_busy"}, 64'(bus.busy), 64'(1));
        chk({name, ".launch_done"}, 64'(bus.done), 64'(0));
        chk({name, ".launch_clear"},
            64'({bus.fail_count, bus.first_fail_syn, bus.fault_map}), 64'(0));
        for (int i = 1; i <= 47; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = (i == poke);
        end
        chk({name, ".done_c47"}, 64'(bus.done), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk({name, ".done_c48"}, 64'(bus.done), 64'(1));
        chk({name, ".busy_off"}, 64'(bus.busy), 64'(0));
        chk({name, ".pass"}, 64'(bus.pass), 64'(ps));
        chk({name, ".fail_count"}, 64'(bus.fail_count), 64'(fc));
        chk({name, ".first_code"}, 64'(bus.first_fail_code), 64'(ffc));
        chk({name, ".first_syn"}, 64'(bus.first_fail_syn), 64'(fsyn));
        chk({name, ".fault_map"}, 64'(bus.fault_map), 64'(fmap));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_over_start", all_out(), 64'(0));
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_hold", all_out(), 64'(0));

        run("good",     0, -1, 1'b1, 5'd0,  4'd0, 16'h0000, 16'h0000);
        run("d5_sa0",   1, -1, 1'b0, 5'd1,  4'd5, 16'h0020, 16'h0020);
        run("upper0",   2, -1, 1'b0, 5'd8,  4'd8, 16'h0100, 16'hFF00);
        run("w_inv",    3, -1, 1'b0, 5'd8,  4'd0, 16'h0003, 16'h00FF);
        run("all0",     4, -1, 1'b0, 5'd16, 4'd0, 16'h0001, 16'hFFFF);
        run("restart",  1, -1, 1'b0, 5'd1,  4'd5, 16'h0020, 16'h0020);
        run("poke_c3",  0,  9, 1'b1, 5'd0,  4'd0, 16'h0000, 16'h0000);

        // Abandon a D5-faulted run during code 7, then rerun it.
        @(negedge clk);
        mode = 1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);
        chk("mid.sel7", 64'(bus.sel_out), 64'(7));
        chk("mid.count", 64'(bus.fail_count), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid.reset_zero", all_out(), 64'(0));
        rst_n = 1'b1;
        run("after_rst", 1, -1, 1'b0, 5'd1, 4'd5, 16'h0020, 16'h0020);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
